mask_centroid: RTL and testbench

Per-frame skin-region centroid stage that consumes the 8-bit binary mask stream produced by the YCbCr threshold stage. It tracks raster position from the video timing signals and accumulates pixel count and coordinate sums for skin pixels. At each frame boundary it computes the floor-mean x/y position with a shared sequential divider. It feeds the hand-tracking / overlay logic downstream.

---
 rtl/skin_segm_pkg.sv | 29 ++
 rtl/seq_divider.sv | 85 ++++++++
 rtl/mask_centroid.sv | 233 +++++++++++++++++++++++
 tb/tb_mask_centroid.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/skin_segm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : skin_segm_pkg
//  Description : Shared constants and types for the skin-segmentation
//                pipeline (mask encoding, centroid FSM states, helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package skin_segm_pkg;

    // Threshold stage encodes a skin pixel as all-zero.
    localparam logic [7:0] MASK_SKIN = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_X = 2'd1,
        DIV_Y = 2'd2,
        DONE  = 2'd3
    } centroid_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Restoring unsigned divider, one quotient bit per cycle,
//                MSB first. i_start launches a division and performs its
//                first step in the same cycle; o_done is high in the cycle
//                that produces the final bit, with o_quot valid alongside.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_start        - launch (operands sampled this cycle)
//                i_num, i_den   - numerator / denominator
//                i_len          - quotient bits to produce (2..Q_W)
//                o_done, o_quot - last-step flag and running quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import skin_segm_pkg::*;
#(
    parameter int N_W   = 32,
    parameter int D_W   = 21,
    parameter int Q_W   = 11,
    parameter int LEN_W = $clog2(Q_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [N_W-1:0]   i_num,
    input  logic [D_W-1:0]   i_den,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quot
);

    // Wide enough for the numerator and for the divisor pre-shifted by Q_W-1.
    localparam int W = max_int(N_W, D_W + Q_W - 1);

    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_den;
    logic [Q_W-1:0]   r_q;
    logic [LEN_W-1:0] r_bit;
    logic             r_run;

    logic             w_active;
    logic             w_ge;
    logic [W-1:0]     w_rem_cur;
    logic [W-1:0]     w_den_cur;
    logic [W-1:0]     w_rem_nxt;
    logic [Q_W-1:0]   w_q_cur;
    logic [Q_W-1:0]   w_q_nxt;
    logic [LEN_W-1:0] w_bit_cur;

    // The divisor starts aligned to the top quotient bit and shifts right
    // each step; the quotient is shifted in from the LSB so after i_len steps
    // it sits right-justified.
    always_comb begin
        w_active  = i_start | r_run;
        w_rem_cur = i_start ? W'(i_num) : r_rem;
        w_den_cur = i_start ? (W'(i_den) << (i_len - LEN_W'(1))) : r_den;
        w_bit_cur = i_start ? (i_len - LEN_W'(1)) : r_bit;
        w_q_cur   = i_start ? '0 : r_q;
        w_ge      = (w_rem_cur >= w_den_cur);
        w_rem_nxt = w_ge ? (w_rem_cur - w_den_cur) : w_rem_cur;
        w_q_nxt   = {w_q_cur[Q_W-2:0], w_ge};
    end

    assign o_done = w_active && (w_bit_cur == '0);
    assign o_quot = w_q_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_den <= '0;
            r_q   <= '0;
            r_bit <= '0;
            r_run <= 1'b0;
        end else if (w_active) begin
            r_rem <= w_rem_nxt;
            r_den <= w_den_cur >> 1;
            r_q   <= w_q_nxt;
            r_bit <= w_bit_cur - LEN_W'(1);
            r_run <= (w_bit_cur != '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mask_centroid.sv
`default_nettype none
// ============================================================================
//  Module      : mask_centroid
//  Description : Per-frame centroid of skin pixels in a binary mask stream.
//                Tracks raster position, accumulates count / x-sum / y-sum,
//                and on each vsync rising edge computes floor means with a
//                time-shared sequential divider.
//  Ports       : clk, rst           - pixel clock, sync active-high reset
//                de, vsync, mask    - video timing and threshold mask
//                x_center, y_center - floor-mean position (last found frame)
//                pix_count, found   - count / detection of last frame
//                valid              - one-cycle result update pulse
//                busy               - division / result stage in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module mask_centroid
    import skin_segm_pkg::*;
#(
    parameter int X_W        = 11,
    parameter int Y_W        = 10,
    parameter int MIN_PIXELS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de,
    input  logic               vsync,
    input  logic [7:0]         mask,
    output logic [X_W-1:0]     x_center,
    output logic [Y_W-1:0]     y_center,
    output logic [X_W+Y_W-1:0] pix_count,
    output logic               found,
    output logic               valid,
    output logic               busy
);

    localparam int CNT_W  = X_W + Y_W;
    localparam int SX_W   = 2 * X_W + Y_W;
    localparam int SY_W   = X_W + 2 * Y_W;
    localparam int N_W    = max_int(SX_W, SY_W);
    localparam int Q_W    = max_int(X_W, Y_W);
    localparam int QMIN_W = min_int(X_W, Y_W);
    localparam int LEN_W  = $clog2(Q_W + 1);

    localparam logic [CNT_W-1:0] c_MIN_PIX = CNT_W'(MIN_PIXELS);

    // Position tracking and edge detection
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_vsync;
    logic             r_de;
    logic             w_vs_rise;
    logic             w_de_fall;

    // Accumulators and divider operands
    logic [CNT_W-1:0] r_acc_cnt;
    logic [SX_W-1:0]  r_acc_x;
    logic [SY_W-1:0]  r_acc_y;
    logic [CNT_W-1:0] r_op_cnt;
    logic [SX_W-1:0]  r_op_x;
    logic [SY_W-1:0]  r_op_y;
    logic             w_acc_en;
    logic             w_low;

    // FSM
    centroid_state_t  r_state;
    centroid_state_t  w_state_nxt;
    logic             r_first;

    // Divider
    logic             w_div_start;
    logic [N_W-1:0]   w_div_num;
    logic [LEN_W-1:0] w_div_len;
    logic             w_div_done;
    logic [Q_W-1:0]   w_quot;

    // Results
    logic [X_W-1:0]   r_qx;
    logic [X_W-1:0]   r_x_center;
    logic [Y_W-1:0]   r_y_center;
    logic [CNT_W-1:0] r_pix_count;
    logic             r_found;
    logic             r_valid;

    assign w_vs_rise = vsync & ~r_vsync;
    assign w_de_fall = ~de & r_de;
    assign w_acc_en  = de && (mask == MASK_SKIN) && !vsync;
    assign w_low     = (r_acc_cnt < c_MIN_PIX) || (r_acc_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync <= 1'b0;
            r_de    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_vsync <= vsync;
            r_de    <= de;
            if (de) begin
                if (r_x != '1) r_x <= r_x + X_W'(1);
            end else if (w_de_fall) begin
                r_x <= '0;
            end
            if (w_vs_rise) begin
                r_y <= '0;
            end else if (w_de_fall && (r_y != '1)) begin
                r_y <= r_y + Y_W'(1);
            end
        end
    end

    // Every vsync edge starts a fresh frame; the previous totals are handed
    // to the divider only when it is free, otherwise they are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_cnt <= '0;
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_op_cnt  <= '0;
            r_op_x    <= '0;
            r_op_y    <= '0;
        end else begin
            if (w_vs_rise) begin
                r_acc_cnt <= '0;
                r_acc_x   <= '0;
                r_acc_y   <= '0;
                if (r_state == IDLE) begin
                    r_op_cnt <= r_acc_cnt;
                    r_op_x   <= r_acc_x;
                    r_op_y   <= r_acc_y;
                end
            end else if (w_acc_en) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                r_acc_x   <= r_acc_x + SX_W'(r_x);
                r_acc_y   <= r_acc_y + SY_W'(r_y);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= (w_state_nxt != r_state);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_vs_rise) w_state_nxt = w_low ? DONE : DIV_X;
            DIV_X:   if (w_div_done) w_state_nxt = DIV_Y;
            DIV_Y:   if (w_div_done) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // One divider serves both axes; a new division is launched on the first
    // cycle of each DIV state.
    always_comb begin
        w_div_start = r_first && ((r_state == DIV_X) || (r_state == DIV_Y));
        w_div_num   = N_W'(r_op_x);
        w_div_len   = LEN_W'(X_W);
        if (r_state == DIV_Y) begin
            w_div_num = N_W'(r_op_y);
            w_div_len = LEN_W'(Y_W);
        end
    end

    seq_divider #(
        .N_W   (N_W),
        .D_W   (CNT_W),
        .Q_W   (Q_W),
        .LEN_W (LEN_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_div_start),
        .i_num   (w_div_num),
        .i_den   (r_op_cnt),
        .i_len   (w_div_len),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    generate
        if (Q_W > QMIN_W) begin : g_quot_unused
            logic w_quot_hi_unused;
            assign w_quot_hi_unused = ^w_quot[Q_W-1:QMIN_W];
        end
    endgenerate

    // Results are loaded on the edge entering DONE so they are stable in the
    // same cycle valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_qx        <= '0;
            r_x_center  <= '0;
            r_y_center  <= '0;
            r_pix_count <= '0;
            r_found     <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if ((r_state == IDLE) && w_vs_rise && w_low) begin
                r_pix_count <= r_acc_cnt;
                r_found     <= 1'b0;
                r_valid     <= 1'b1;
            end
            if ((r_state == DIV_X) && w_div_done) begin
                r_qx <= w_quot[X_W-1:0];
            end
            if ((r_state == DIV_Y) && w_div_done) begin
                r_x_center  <= r_qx;
                r_y_center  <= w_quot[Y_W-1:0];
                r_pix_count <= r_op_cnt;
                r_found     <= 1'b1;
                r_valid     <= 1'b1;
            end
        end
    end

    assign x_center  = r_x_center;
    assign y_center  = r_y_center;
    assign pix_count = r_pix_count;
    assign found     = r_found;
    assign valid     = r_valid;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mask_centroid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mask_centroid
//  Description : Self-checking bench for mask_centroid. Two instances share
//                one stimulus stream (MIN_PIXELS 1 and 16); a reference model
//                pushes expected results at each vsync edge and they are
//                popped when the matching valid pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_centroid;
    import skin_segm_pkg::*;

    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam int LAT_FOUND = X_W + Y_W + 1;

    typedef struct {
        int cyc;
        int x;
        int y;
        int cnt;
        bit fnd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic de;
    logic vsync;
    logic [7:0] mask;

    logic [X_W-1:0]     xc [2];
    logic [Y_W-1:0]     yc [2];
    logic [X_W+Y_W-1:0] pc [2];
    logic               fd [2];
    logic               vl [2];
    logic               bz [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_cnt, m_sx, m_sy;
    int   ready [2];
    int   hx [2];
    int   hy [2];
    int   min_pix [2] = '{1, 16};
    exp_t sbq [2][$];

    mask_centroid #(.X_W(X_W), .Y_W(Y_W), .MIN_PIXELS(1)) u_dut_min1 (
        .clk(clk), .rst(rst), .de(de), .vsync(vsync), .mask(mask),
        .x_center(xc[0]), .y_center(yc[0]), .pix_count(pc[0]),
        .found(fd[0]), .valid(vl[0]), .busy(bz[0])
    );

    mask_centroid #(.X_W(X_W), .Y_W(Y_W), .MIN_PIXELS(16)) u_dut_min16 (
        .clk(clk), .rst(rst), .de(de), .vsync(vsync), .mask(mask),
        .x_center(xc[1]), .y_center(yc[1]), .pix_count(pc[1]),
        .found(fd[1]), .valid(vl[1]), .busy(bz[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (vl[d] === 1'b1) begin
                if (sbq[d].size() == 0) begin
                    chk($sformatf("d%0d_valid_unexpected", d), 32'(vl[d]), 32'd0);
                end else begin
                    e = sbq[d].pop_front();
                    chk($sformatf("d%0d_valid_cycle", d), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("d%0d_x_center", d), 32'(xc[d]), 32'(e.x));
                    chk($sformatf("d%0d_y_center", d), 32'(yc[d]), 32'(e.y));
                    chk($sformatf("d%0d_pix_count", d), 32'(pc[d]), 32'(e.cnt));
                    chk($sformatf("d%0d_found", d), 32'(fd[d]), 32'(e.fnd));
                end
            end
        end
    endtask

    // Outputs are sampled at the falling edge; inputs change 1 ns after the
    // rising edge.
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_sx  = 0;
        m_sy  = 0;
    endtask

    task automatic capture();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (cyc >= ready[d]) begin
                e.fnd = (m_cnt >= min_pix[d]) && (m_cnt != 0);
                if (e.fnd) begin
                    hx[d] = m_sx / m_cnt;
                    hy[d] = m_sy / m_cnt;
                end
                e.cyc = cyc + (e.fnd ? LAT_FOUND : 1);
                e.x   = hx[d];
                e.y   = hy[d];
                e.cnt = m_cnt;
                sbq[d].push_back(e);
                ready[d] = e.cyc + 1;
            end
        end
        model_clear();
    endtask

    task automatic pixel(input int x, input int y, input bit skin);
        de    = 1'b1;
        vsync = 1'b0;
        mask  = skin ? MASK_SKIN : 8'($urandom_range(1, 255));
        if (skin) begin
            m_cnt++;
            m_sx += x;
            m_sy += y;
        end
        tick();
    endtask

    task automatic idle_cycles(input int n);
        de   = 1'b0;
        mask = 8'($urandom_range(0, 255));
        repeat (n) tick();
    endtask

    task automatic frame(input int w, input int h, input int x0, input int x1,
                         input int y0, input int y1);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                pixel(c, r, (c >= x0) && (c <= x1) && (r >= y0) && (r <= y1));
            end
            idle_cycles(2);
        end
    endtask

    task automatic vs_rise();
        de    = 1'b0;
        vsync = 1'b1;
        capture();
        tick();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (((sbq[0].size() + sbq[1].size()) > 0) && (n < 200)) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(sbq[0].size() + sbq[1].size()), 32'd0);
        idle_cycles(2);
    endtask

    task automatic end_frame(input string tag);
        vs_rise();
        repeat (2) tick();
        vsync = 1'b0;
        wait_drain(tag);
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_x", tag, d), 32'(xc[d]), 32'd0);
            chk($sformatf("%s_d%0d_y", tag, d), 32'(yc[d]), 32'd0);
            chk($sformatf("%s_d%0d_cnt", tag, d), 32'(pc[d]), 32'd0);
            chk($sformatf("%s_d%0d_found", tag, d), 32'(fd[d]), 32'd0);
            chk($sformatf("%s_d%0d_valid", tag, d), 32'(vl[d]), 32'd0);
            chk($sformatf("%s_d%0d_busy", tag, d), 32'(bz[d]), 32'd0);
        end
    endtask

    task automatic model_reset();
        model_clear();
        for (int d = 0; d < 2; d++) begin
            sbq[d].delete();
            ready[d] = 0;
            hx[d]    = 0;
            hy[d]    = 0;
        end
    endtask

    initial begin
        int c0;
        rst   = 1'b1;
        de    = 1'b0;
        vsync = 1'b0;
        mask  = 8'hFF;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check_zero("reset");

        // 2x2 block: sum_x=18, sum_y=26, count 4
        frame(8, 8, 4, 5, 6, 7);
        end_frame("block2x2");

        // single pixel at (3,2)
        frame(8, 4, 3, 3, 2, 2);
        end_frame("single");

        // no skin: found=0, centers hold
        frame(8, 4, 1, 0, 1, 0);
        end_frame("empty");

        // 15 pixels, one short of the larger threshold
        frame(8, 4, 0, 4, 0, 2);
        end_frame("cnt15");

        // 16 pixels, fractional means 4.5 / 3.5
        frame(8, 6, 3, 6, 2, 5);
        end_frame("cnt16");

        // second vsync edge while the first frame is still dividing
        frame(8, 4, 7, 7, 3, 3);
        vs_rise();
        tick();
        vsync = 1'b0;
        for (int c = 0; c < 3; c++) pixel(c, 0, 1'b1);
        idle_cycles(1);
        vs_rise();
        repeat (2) tick();
        vsync = 1'b0;
        wait_drain("busy_edge");

        // stats restart from zero after the dropped frame
        frame(8, 4, 0, 3, 0, 3);
        end_frame("after_drop");

        // reset during the y division
        frame(8, 4, 0, 3, 0, 3);
        c0 = cyc;
        vs_rise();
        repeat (2) tick();
        vsync = 1'b0;
        while (cyc < c0 + X_W + 4) tick();
        chk("busy_mid_div", 32'(bz[0]), 32'd1);
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        check_zero("mid_div_rst");
        idle_cycles(LAT_FOUND + 4);

        // normal frame after the abort
        frame(12, 4, 8, 11, 0, 3);
        end_frame("post_rst");

        chk("final_drain", 32'(sbq[0].size() + sbq[1].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
